uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Packet consumer directly downstream of the 64-bit UART receiver. Unloads each received word, checks parity, chip ID and magic number, and applies configuration writes to the register map. It answers configuration reads with a reply packet toward the UART transmitter, and forwards data packets and foreign-chip packets unchanged on the same transmit handshake.

## Interface
- `WIDTH`, 64: packet width; only 64 is supported; field positions are fixed.
- `MAGIC`, 32'h8950_4E47: required value of packet bits [57:26] for configuration packets.
- `clk` in 1: system clock, same clock as the receiver.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in WIDTH: word from receiver.
- `rx_empty` in 1: low = word waiting.
- `parity_error` in 1: receiver parity flag for `rx_data`.
- `uld_rx_data` out 1: one-cycle unload pulse to receiver.
- `chip_id` in 8: this chip's ID; 8'hFF is broadcast.
- `cfg_addr` out 8: register address.
- `cfg_wr_data` out 8: register write data.
- `cfg_wr_en` out 1: one-cycle write strobe.
- `cfg_rd_data` in 8: register read data, valid one cycle after `cfg_addr` changes.
- `tx_data` out WIDTH: packet to transmitter.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: transmitter accepts when high with `tx_valid`.
- `parity_err_cnt` out 8: saturating count of dropped parity-error packets.
- `magic_err_cnt` out 8: saturating count of dropped bad-magic packets.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- Packet fields:
  - [1:0] type: 00 unused, 01 data, 10 cfg write, 11 cfg read.
  - [9:2] chip ID.
  - [17:10] address.
  - [25:18] data.
  - [57:26] magic.
  - [62] downstream bit.
  - [63] odd parity.
- FSM states: IDLE, DECODE, RD_WAIT, SEND.
- IDLE: when `rx_empty`=0, latch `rx_data` and `parity_error` into `pkt`/`pkt_perr`, register `uld_rx_data`=1, go to DECODE.
- DECODE checks the following conditions in priority order:
  1. `pkt_perr`: drop, increment `parity_err_cnt`, go to IDLE.
  2. Type 00: drop silently, go to IDLE.
  3. Type 01: forward `pkt` unchanged, go to SEND.
  4. Type 1x, chip ID ≠ `chip_id` and ≠ 8'hFF: forward unchanged, go to SEND.
  5. Type 1x, magic ≠ `MAGIC`: drop, increment `magic_err_cnt`, go to IDLE.
  6. Type 10: drive `cfg_addr`/`cfg_wr_data`, pulse `cfg_wr_en`. If chip ID = 8'hFF, also forward to SEND; otherwise go to IDLE.
  7. Type 11, chip ID = `chip_id`: drive `cfg_addr`, go to RD_WAIT.
  8. Type 11, chip ID = 8'hFF: drop, go to IDLE (no broadcast reads).
- RD_WAIT: build the reply and go to SEND. Reply fields:
  - type = 11, chip ID = `chip_id`, address = `pkt` address, data = `cfg_rd_data`.
  - magic = `MAGIC`, [61:58] = 0, [62] = 1.
  - [63] = ~^reply[62:0], so the receiver's parity check passes.
- SEND: `tx_valid`=1 with `tx_data` held stable. On `tx_valid`&&`tx_ready`, deassert `tx_valid` next cycle and go to IDLE.
- Counters saturate at 8'hFF.
- `uld_rx_data` is never asserted outside the cycle after IDLE capture. A pending word during DECODE/RD_WAIT/SEND stays in the receiver until the FSM returns to IDLE.

## Timing
- Reset values:
  - Outputs: `uld_rx_data`, `cfg_wr_en`, `tx_valid` = 0; `cfg_addr`, `cfg_wr_data`, `tx_data`, both counters = 0; `busy` = 0.
  - Internal: state = IDLE, `pkt` = 0.
- Cycle N: IDLE sees `rx_empty`=0.
- Cycle N+1: `uld_rx_data`=1, DECODE.
- Cycle N+2 (write): `cfg_wr_en`=1, state IDLE. `rx_empty` is high again by N+2, so there is no double capture.
- Read: `cfg_addr` valid N+2, reply `tx_valid`=1 at N+3.
- Forward: `tx_valid`=1 at N+2.
- Minimum spacing between unload pulses: 2 cycles (drop/write path).
- Reset asserted mid-packet: FSM to IDLE, `tx_valid` drops the following cycle, and the latched packet is discarded. The pending receiver word is re-captured after reset.
- `tx_ready` held high before `tx_valid`: transfer completes in the first SEND cycle.

## Configuration
- `UART_CMD_DECODER_ERR_CNT_EN` defined: `parity_err_cnt`/`magic_err_cnt` implemented as above.
- Not defined: both outputs tied to 8'h00, no counter flops. Drop behaviour is unchanged.

## Test plan
- Reset, then cfg write: `chip_id`=8'h12, addr 8'h05, data 8'hA5, good magic and parity -> one `uld_rx_data` pulse, and `cfg_wr_en` for one cycle at N+2 with `cfg_addr`=8'h05, `cfg_wr_data`=8'hA5. No `tx_valid`.
- Cfg read: addr 8'h05, `cfg_rd_data`=8'h3C -> `tx_valid` at N+3 with type 11, data 8'h3C, bit 62=1, correct odd parity. With `tx_ready` held low for 5 cycles, `tx_data` stays stable and `busy` stays 1.
- Data packet (type 01) and cfg packet with chip ID 8'h34 -> each forwarded bit-exact, and `cfg_wr_en` never asserts.
- `parity_error`=1 on 300 consecutive packets -> no write, no tx, and `parity_err_cnt` saturates at 8'hFF (macro on) or reads 0 (macro off).
- Own-chip write with magic 32'h0 -> dropped, `magic_err_cnt`=1. Broadcast write (chip ID 8'hFF) -> `cfg_wr_en` pulse and the packet forwarded.
- Reset asserted during SEND -> `tx_valid`=0 the next cycle, state IDLE, and the following packet is decoded normally.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// Command decoder behind the 64-bit UART receiver: validates packets, applies config writes,
// answers config reads and forwards everything else. Error counters built only with UART_CMD_DECODER_ERR_CNT_EN.
module uart_cmd_decoder #(
    parameter int          WIDTH = 64,
    parameter logic [31:0] MAGIC = 32'h8950_4E47
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_empty,
    input  logic             parity_error,
    output logic             uld_rx_data,
    input  logic [7:0]       chip_id,
    output logic [7:0]       cfg_addr,
    output logic [7:0]       cfg_wr_data,
    output logic             cfg_wr_en,
    input  logic [7:0]       cfg_rd_data,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       parity_err_cnt,
    output logic [7:0]       magic_err_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, DECODE, RD_WAIT, SEND} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pkt_reg, pkt_next;
    logic             pkt_perr_reg, pkt_perr_next;
    logic             uld_reg, uld_next;
    logic [7:0]       cfg_addr_reg, cfg_addr_next;
    logic [7:0]       cfg_wr_data_reg, cfg_wr_data_next;
    logic             cfg_wr_en_reg, cfg_wr_en_next;
    logic [WIDTH-1:0] tx_data_reg, tx_data_next;
    logic             tx_valid_reg, tx_valid_next;
    logic             inc_perr, inc_magic;

    logic [1:0]       pkt_type;
    logic [7:0]       pkt_id;
    logic             id_own, id_bcast;
    logic [62:0]      reply_body;
    logic [WIDTH-1:0] reply;

    assign pkt_type = pkt_reg[1:0];
    assign pkt_id   = pkt_reg[9:2];
    assign id_own   = (pkt_id == chip_id);
    assign id_bcast = (pkt_id == 8'hFF);

    // Reply parity bit makes the total number of ones odd, matching the receiver's check.
    assign reply_body = {1'b1, 4'h0, MAGIC, cfg_rd_data, pkt_reg[17:10], chip_id, 2'b11};
    assign reply      = {~^reply_body, reply_body};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            pkt_reg         <= '0;
            pkt_perr_reg    <= 1'b0;
            uld_reg         <= 1'b0;
            cfg_addr_reg    <= 8'h00;
            cfg_wr_data_reg <= 8'h00;
            cfg_wr_en_reg   <= 1'b0;
            tx_data_reg     <= '0;
            tx_valid_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pkt_reg         <= pkt_next;
            pkt_perr_reg    <= pkt_perr_next;
            uld_reg         <= uld_next;
            cfg_addr_reg    <= cfg_addr_next;
            cfg_wr_data_reg <= cfg_wr_data_next;
            cfg_wr_en_reg   <= cfg_wr_en_next;
            tx_data_reg     <= tx_data_next;
            tx_valid_reg    <= tx_valid_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pkt_next         = pkt_reg;
        pkt_perr_next    = pkt_perr_reg;
        uld_next         = 1'b0;
        cfg_addr_next    = cfg_addr_reg;
        cfg_wr_data_next = cfg_wr_data_reg;
        cfg_wr_en_next   = 1'b0;
        tx_data_next     = tx_data_reg;
        tx_valid_next    = tx_valid_reg;
        inc_perr         = 1'b0;
        inc_magic        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_empty) begin
                    pkt_next      = rx_data;
                    pkt_perr_next = parity_error;
                    uld_next      = 1'b1;
                    state_next    = DECODE;
                end
            end
            DECODE: begin
                state_next = IDLE;
                if (pkt_perr_reg) begin
                    inc_perr = 1'b1;
                end else if (pkt_type == 2'b00) begin
                    state_next = IDLE;
                end else if (pkt_type == 2'b01 || (!id_own && !id_bcast)) begin
                    tx_data_next  = pkt_reg;
                    tx_valid_next = 1'b1;
                    state_next    = SEND;
                end else if (pkt_reg[57:26] != MAGIC) begin
                    inc_magic = 1'b1;
                end else if (pkt_type == 2'b10) begin
                    cfg_addr_next    = pkt_reg[17:10];
                    cfg_wr_data_next = pkt_reg[25:18];
                    cfg_wr_en_next   = 1'b1;
                    // Broadcast writes are applied locally and still passed down the chain.
                    if (id_bcast && !id_own) begin
                        tx_data_next  = pkt_reg;
                        tx_valid_next = 1'b1;
                        state_next    = SEND;
                    end
                end else if (id_own) begin
                    cfg_addr_next = pkt_reg[17:10];
                    state_next    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                tx_data_next  = reply;
                tx_valid_next = 1'b1;
                state_next    = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    tx_valid_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_CMD_DECODER_ERR_CNT_EN
    logic [7:0] err_cnt_reg [2];
    logic [1:0] err_inc;

    assign err_inc = {inc_magic, inc_perr};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
            always_ff @(posedge clk) begin
                if (reset)
                    err_cnt_reg[gi] <= 8'h00;
                else if (err_inc[gi] && err_cnt_reg[gi] != 8'hFF)
                    err_cnt_reg[gi] <= err_cnt_reg[gi] + 8'd1;
            end
        end
    endgenerate

    assign parity_err_cnt = err_cnt_reg[0];
    assign magic_err_cnt  = err_cnt_reg[1];
`else
    logic unused_err_inc;
    assign unused_err_inc = inc_perr ^ inc_magic;
    assign parity_err_cnt = 8'h00;
    assign magic_err_cnt  = 8'h00;
`endif

    assign uld_rx_data = uld_reg;
    assign cfg_addr    = cfg_addr_reg;
    assign cfg_wr_data = cfg_wr_data_reg;
    assign cfg_wr_en   = cfg_wr_en_reg;
    assign tx_data     = tx_data_reg;
    assign tx_valid    = tx_valid_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder; expected packets and counts are computed here.
module tb_uart_cmd_decoder;

    localparam logic [31:0] MAGIC = 32'h8950_4E47;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] rx_data;
    logic        rx_empty;
    logic        parity_error;
    logic        uld_rx_data;
    logic [7:0]  chip_id;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_wr_data;
    logic        cfg_wr_en;
    logic [7:0]  cfg_rd_data;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  parity_err_cnt;
    logic [7:0]  magic_err_cnt;
    logic        busy;

    int tests  = 0;
    int failed = 0;
    int uld_cnt = 0;
    int wr_cnt  = 0;
    int tx_cnt  = 0;

    uart_cmd_decoder #(.WIDTH(64), .MAGIC(MAGIC)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
        .parity_error(parity_error), .uld_rx_data(uld_rx_data), .chip_id(chip_id),
        .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data), .cfg_wr_en(cfg_wr_en),
        .cfg_rd_data(cfg_rd_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .parity_err_cnt(parity_err_cnt),
        .magic_err_cnt(magic_err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (uld_rx_data) uld_cnt <= uld_cnt + 1;
        if (cfg_wr_en)   wr_cnt  <= wr_cnt + 1;
        if (tx_valid)    tx_cnt  <= tx_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] typ, input logic [7:0] id,
                                       input logic [7:0] addr, input logic [7:0] data,
                                       input logic [31:0] magic, input logic down);
        logic [62:0] b;
        b = {down, 4'h0, magic, data, addr, id, typ};
        return {~^b, b};
    endfunction

    // Offer a word at cycle N; returns at the negedge of N+1 with the receiver emptied.
    task automatic present(input logic [63:0] w, input logic perr);
        rx_data      = w;
        parity_error = perr;
        rx_empty     = 1'b0;
        @(negedge clk);
        rx_empty     = 1'b1;
        parity_error = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] w, exp_reply;
        int u0, w0, t0;
        logic stable;
        logic [7:0] exp_perr, exp_magic;
`ifdef UART_CMD_DECODER_ERR_CNT_EN
        exp_perr  = 8'hFF;
        exp_magic = 8'h01;
`else
        exp_perr  = 8'h00;
        exp_magic = 8'h00;
`endif
        reset = 1'b1; rx_data = '0; rx_empty = 1'b1; parity_error = 1'b0;
        chip_id = 8'h12; cfg_rd_data = 8'h3C; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uld", uld_rx_data, 0);
        check("rst_wr_en", cfg_wr_en, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_cfg_addr", cfg_addr, 0);
        check("rst_cfg_wr_data", cfg_wr_data, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_perr_cnt", parity_err_cnt, 0);
        check("rst_magic_cnt", magic_err_cnt, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // Own-chip config write
        u0 = uld_cnt; t0 = tx_cnt;
        present(mk(2'b10, 8'h12, 8'h05, 8'hA5, MAGIC, 1'b0), 1'b0);
        check("wr_uld", uld_rx_data, 1);
        check("wr_busy", busy, 1);
        @(negedge clk);
        check("wr_en", cfg_wr_en, 1);
        check("wr_addr", cfg_addr, 8'h05);
        check("wr_data", cfg_wr_data, 8'hA5);
        check("wr_idle", busy, 0);
        @(negedge clk);
        check("wr_en_pulse", cfg_wr_en, 0);
        check("wr_uld_once", uld_cnt - u0, 1);
        check("wr_no_tx", tx_cnt - t0, 0);
        $display("[TB] cfg write addr=05 data=A5 done");

        // Own-chip config read with back-pressure
        exp_reply = mk(2'b11, 8'h12, 8'h05, 8'h3C, MAGIC, 1'b1);
        present(mk(2'b11, 8'h12, 8'h05, 8'h00, MAGIC, 1'b0), 1'b0);
        @(negedge clk);
        check("rd_addr", cfg_addr, 8'h05);
        check("rd_no_valid_yet", tx_valid, 0);
        @(negedge clk);
        check("rd_valid", tx_valid, 1);
        check("rd_reply", tx_data, exp_reply);
        check("rd_bit62", tx_data[62], 1);
        check("rd_odd_parity", ^tx_data, 1);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (tx_data !== exp_reply || tx_valid !== 1'b1 || busy !== 1'b1) stable = 1'b0;
        end
        check("rd_hold", stable, 1);
        tx_ready = 1'b1;
        @(negedge clk);
        check("rd_accept_valid", tx_valid, 0);
        check("rd_accept_idle", busy, 0);
        $display("[TB] cfg read addr=05 reply %h", exp_reply);

        // Forwarding: data packet and foreign-chip config packet, tx_ready held high
        w0 = wr_cnt;
        w = 64'h7123_4567_89AB_CDE5;
        present(w, 1'b0);
        @(negedge clk);
        check("fwd_data_valid", tx_valid, 1);
        check("fwd_data", tx_data, w);
        @(negedge clk);
        check("fwd_data_done", tx_valid, 0);
        $display("[TB] data forward %h", w);
        w = mk(2'b10, 8'h34, 8'h07, 8'h99, MAGIC, 1'b0);
        present(w, 1'b0);
        @(negedge clk);
        check("fwd_cfg_valid", tx_valid, 1);
        check("fwd_cfg", tx_data, w);
        @(negedge clk);
        check("fwd_cfg_done", tx_valid, 0);
        check("fwd_no_wr", wr_cnt - w0, 0);
        $display("[TB] foreign cfg forward %h", w);

        // Parity-error burst
        u0 = uld_cnt; w0 = wr_cnt; t0 = tx_cnt;
        for (int i = 0; i < 300; i++) begin
            present(mk(2'b10, 8'h12, i[7:0], 8'h11, MAGIC, 1'b0), 1'b1);
            @(negedge clk);
        end
        @(negedge clk);
        check("perr_uld", uld_cnt - u0, 300);
        check("perr_no_wr", wr_cnt - w0, 0);
        check("perr_no_tx", tx_cnt - t0, 0);
        check("perr_cnt", parity_err_cnt, exp_perr);
        check("perr_magic_cnt", magic_err_cnt, 0);
        $display("[TB] 300 parity-error packets, count %h", parity_err_cnt);

        // Bad magic, then broadcast write
        w0 = wr_cnt; t0 = tx_cnt;
        present(mk(2'b10, 8'h12, 8'h06, 8'h77, 32'h0, 1'b0), 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("magic_cnt", magic_err_cnt, exp_magic);
        check("magic_no_wr", wr_cnt - w0, 0);
        check("magic_no_tx", tx_cnt - t0, 0);
        $display("[TB] bad magic dropped");
        tx_ready = 1'b0;
        w = mk(2'b10, 8'hFF, 8'h09, 8'h5A, MAGIC, 1'b0);
        present(w, 1'b0);
        @(negedge clk);
        check("bc_wr_en", cfg_wr_en, 1);
        check("bc_addr", cfg_addr, 8'h09);
        check("bc_data", cfg_wr_data, 8'h5A);
        check("bc_valid", tx_valid, 1);
        check("bc_fwd", tx_data, w);
        tx_ready = 1'b1;
        @(negedge clk);
        check("bc_done", tx_valid, 0);
        $display("[TB] broadcast write forwarded %h", w);

        // Reset while in SEND
        tx_ready = 1'b0;
        present(64'h0000_0000_0000_0AB1, 1'b0);
        @(negedge clk);
        check("rst_send_valid", tx_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_send_drop", tx_valid, 0);
        check("rst_send_idle", busy, 0);
        reset = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        present(mk(2'b10, 8'h12, 8'h0A, 8'hC3, MAGIC, 1'b0), 1'b0);
        @(negedge clk);
        check("post_rst_wr_en", cfg_wr_en, 1);
        check("post_rst_addr", cfg_addr, 8'h0A);
        check("post_rst_data", cfg_wr_data, 8'hC3);
        check("post_rst_perr_cnt", parity_err_cnt, 0);
        $display("[TB] reset during SEND, next write addr=0A applied");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
